// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//
// Hazard scheduler for a 5-stage pipeline (IF, ID, EX, MEM, WB). Each
// architectural register has a small down-counter scoreboard that records how
// many more cycles a pending write keeps the register unreadable from ID. Each
// cycle the instruction in ID either issues, stalls behind a RAW hazard, or is
// squashed by a taken branch resolved in EX.
//
// Configuration macro: HAZARD_FORWARDING_EN
//   defined   : EX/MEM and MEM/WB forwarding exist; loads block for 1 cycle,
//               ALU results are never tracked.
//   undefined : no forwarding; every register write blocks readers for 2 cycles.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-low reset
//   id_valid         ID holds a real instruction (not a bubble)
//   id_rs1/id_rs2    source register indices of the ID instruction
//   id_use_rs1/2     the corresponding source is actually read
//   id_rd            destination register of the ID instruction
//   id_reg_write     the ID instruction writes id_rd
//   id_is_load       the ID instruction is a load
//   ex_branch_taken  the branch currently in EX is taken
//   pc_hold          PC keeps its value
//   ifid_hold        IF/ID register keeps its value
//   ifid_flush       IF/ID register loads a NOP
//   idex_bubble      ID/EX register loads a NOP
//   id_issue         the ID instruction advances to EX this cycle
//   busy_mask        bit r set while register r has a pending tracked write
//   stall_count      saturating count of hazard stall cycles
//   flush_count      saturating count of taken-branch flushes
//
// Issue handshake: id_valid offers the ID instruction; id_issue is the
// acceptance for that same cycle. An instruction is consumed exactly on a
// cycle where id_valid=1 and id_issue=1; on a stall the upstream stages hold
// it (pc_hold/ifid_hold) and offer it again next cycle, unchanged.

module pipeline_hazard_ctrl #(
  parameter int NREG     = 32,
  parameter int RW       = 5,
  parameter int ZERO_REG = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RW-1:0]    id_rs1,
  input  logic [RW-1:0]    id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [RW-1:0]    id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             id_issue,
  output logic [NREG-1:0]  busy_mask,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [RW-1:0] ZR = RW'(ZERO_REG);

  // Scoreboard load value per producer type: the number of cycles a
  // dependent reader in ID must wait directly after the producer issues.
`ifdef HAZARD_FORWARDING_EN
  localparam logic [1:0] L_LOAD = 2'd1;
  localparam logic [1:0] L_ALU  = 2'd0;
`else
  // Without forwarding the value is only readable once the producer is in
  // WB (write-first register file), so loads and ALU ops wait alike.
  localparam logic [1:0] L_LOAD = 2'd2;
  localparam logic [1:0] L_ALU  = 2'd2;
`endif

  logic [1:0] sb [NREG];

  logic       rs1_busy;
  logic       rs2_busy;
  logic       hazard;
  logic [1:0] load_val;
  logic       sb_set;
  logic       stall_inc;
  logic       flush_inc;

  // Hazard detection. The zero register is excluded explicitly even though
  // its counter is never loaded, so a reader of it can never stall.
  always_comb begin
    rs1_busy = id_use_rs1 && (id_rs1 != ZR) && (sb[id_rs1] != 2'd0);
    rs2_busy = id_use_rs2 && (id_rs2 != ZR) && (sb[id_rs2] != 2'd0);
    hazard   = id_valid && (rs1_busy || rs2_busy);
  end

  // Control outputs. A taken branch outranks a hazard: the ID instruction is
  // on the wrong path, so it is squashed instead of being held.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    id_issue    = 1'b0;
    if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (hazard) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      id_issue = id_valid;
    end
  end

  always_comb begin
    load_val  = id_is_load ? L_LOAD : L_ALU;
    sb_set    = id_issue && id_reg_write && (id_rd != ZR) && (load_val != 2'd0);
    flush_inc = ex_branch_taken;
    stall_inc = hazard && !ex_branch_taken;
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      busy_mask[r] = (sb[r] != 2'd0);
    end
  end

  // Scoreboard: every pending counter counts down each cycle, stall or not,
  // because bubbles still move the producer through EX/MEM/WB. A new write
  // to the same register reloads the counter instead of decrementing it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        sb[r] <= 2'd0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (sb_set && (id_rd == RW'(r))) begin
          sb[r] <= load_val;
        end else if (sb[r] != 2'd0) begin
          sb[r] <= sb[r] - 2'd1;
        end
      end
    end
  end

  // Statistics, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_inc && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (flush_inc && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int NREG  = 32;
  localparam int RW    = 5;
  localparam int CNT_W = 4;   // small so saturation is reachable
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             id_valid;
  logic [RW-1:0]    id_rs1;
  logic [RW-1:0]    id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [RW-1:0]    id_rd;
  logic             id_reg_write;
  logic             id_is_load;
  logic             ex_branch_taken;
  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             id_issue;
  logic [NREG-1:0]  busy_mask;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  logic [4:0] ctrl;
  assign ctrl = {pc_hold, ifid_hold, ifid_flush, idex_bubble, id_issue};

  int n_vec = 0;
  int n_err = 0;

  pipeline_hazard_ctrl #(
    .NREG(NREG), .RW(RW), .ZERO_REG(0), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .id_issue(id_issue), .busy_mask(busy_mask),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    id_valid = 0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = '0; id_reg_write = 0; id_is_load = 0; ex_branch_taken = 0;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = rw; id_is_load = ld;
  endtask

  // Inputs change and outputs are sampled 1-2 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
  endtask

  // Producer that reads nothing, so it always issues.
  task automatic issue_producer(input logic [4:0] rd, input logic ld);
    set_id(1, 5'd1, 5'd2, 0, 0, rd, 1, ld);
    tick();
    idle_inputs();
  endtask

  // Holds one consumer in ID until it issues (bounded), counting stall
  // cycles, cycles with its rs1 busy and cycles with any register busy.
  task automatic run_consumer(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic ld,
                              output int stalls, output int busy_src,
                              output int any_busy, output logic issued);
    stalls = 0; busy_src = 0; any_busy = 0; issued = 0;
    set_id(1, rs1, rs2, 1, 1, rd, 1, ld);
    for (int i = 0; i < 6 && !issued; i++) begin
      #1;
      if (busy_mask[rs1]) busy_src++;
      if (busy_mask != '0) any_busy++;
      if (id_issue) issued = 1;
      else if (pc_hold && idex_bubble) stalls++;
      tick();
    end
    idle_inputs();
  endtask

  // ---------------- reference model ----------------
  // Register r is readable from ID at model cycle ready_at[r] onwards.
  int ready_at [NREG];
  int mc;
  int m_stall;
  int m_flush;

  function automatic int lat(input logic ld);
`ifdef HAZARD_FORWARDING_EN
    return ld ? 1 : 0;
`else
    return 2;
`endif
  endfunction

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) ready_at[r] = 0;
    m_stall = 0;
    m_flush = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 0;
    #3;
    n_vec++; if (ctrl !== 5'b0) begin n_err++; $display("FAIL reset_ctrl got %b exp %b", ctrl, 5'b0); end
    n_vec++; if (busy_mask !== '0) begin n_err++; $display("FAIL reset_busy got %h exp 0", busy_mask); end
    n_vec++; if (stall_count !== '0) begin n_err++; $display("FAIL reset_stall got %0d exp 0", stall_count); end
    n_vec++; if (flush_count !== '0) begin n_err++; $display("FAIL reset_flush got %0d exp 0", flush_count); end
    tick();
    reset = 1;
    tick();
    #1;
    n_vec++; if (ctrl !== 5'b0 || busy_mask !== '0) begin n_err++; $display("FAIL post_reset got ctrl %b busy %h exp 0", ctrl, busy_mask); end
  endtask

`ifdef HAZARD_FORWARDING_EN
  task automatic test_load_use();
    int st, bs, ab; logic iss;
    do_reset();
    issue_producer(5'd12, 1'b1);                       // LDUR X12
    run_consumer(5'd12, 5'd13, 5'd14, 1'b0, st, bs, ab, iss); // SUB X14,X12,X13
    n_vec++; if (iss !== 1'b1) begin n_err++; $display("FAIL load_use_issue got %b exp 1", iss); end
    n_vec++; if (st != 1) begin n_err++; $display("FAIL load_use_stalls got %0d exp 1", st); end
    n_vec++; if (stall_count !== 4'd1) begin n_err++; $display("FAIL load_use_count got %0d exp 1", stall_count); end
  endtask

  task automatic test_alu_b2b();
    int st, bs, ab; logic iss;
    do_reset();
    issue_producer(5'd11, 1'b0);                       // ADD X11,X1,X10
    run_consumer(5'd11, 5'd11, 5'd12, 1'b1, st, bs, ab, iss); // LDUR X12,[X11]
    n_vec++; if (iss !== 1'b1 || st != 0) begin n_err++; $display("FAIL alu_b2b_stalls got %0d (issued %b) exp 0", st, iss); end
    n_vec++; if (ab != 0) begin n_err++; $display("FAIL alu_b2b_busy got %0d busy cycles exp 0", ab); end
    n_vec++; if (stall_count !== 4'd0) begin n_err++; $display("FAIL alu_b2b_count got %0d exp 0", stall_count); end
  endtask
`else
  task automatic test_no_forwarding();
    int st, bs, ab; logic iss;
    // Consumer right after producer.
    do_reset();
    issue_producer(5'd5, 1'b0);                        // ADD X5
    run_consumer(5'd5, 5'd6, 5'd16, 1'b0, st, bs, ab, iss);  // SUB X16,X5,X6
    n_vec++; if (iss !== 1'b1 || st != 2) begin n_err++; $display("FAIL adj_stalls got %0d (issued %b) exp 2", st, iss); end
    n_vec++; if (bs != 2) begin n_err++; $display("FAIL adj_busy5 got %0d exp 2", bs); end
    n_vec++; if (stall_count !== 4'd2) begin n_err++; $display("FAIL adj_count got %0d exp 2", stall_count); end
    #1;
    n_vec++; if (busy_mask !== 32'h0001_0000) begin n_err++; $display("FAIL adj_busy16 got %h exp 00010000", busy_mask); end
    // One NOP in between.
    do_reset();
    issue_producer(5'd5, 1'b0);
    tick();
    run_consumer(5'd5, 5'd6, 5'd16, 1'b0, st, bs, ab, iss);
    n_vec++; if (iss !== 1'b1 || st != 1) begin n_err++; $display("FAIL gap1_stalls got %0d (issued %b) exp 1", st, iss); end
    // Two NOPs in between.
    do_reset();
    issue_producer(5'd5, 1'b0);
    tick();
    tick();
    run_consumer(5'd6, 5'd5, 5'd16, 1'b0, st, bs, ab, iss);
    n_vec++; if (iss !== 1'b1 || st != 0) begin n_err++; $display("FAIL gap2_stalls got %0d (issued %b) exp 0", st, iss); end
  endtask
`endif

  task automatic test_branch_flush();
    do_reset();
    issue_producer(5'd7, 1'b1);                        // pending load X7
    set_id(1, 5'd7, 5'd3, 1, 0, 5'd9, 1, 0);           // hazarding reader, writes X9
    ex_branch_taken = 1;
    #1;
    n_vec++; if (ctrl !== 5'b00110) begin n_err++; $display("FAIL flush_ctrl got %b exp 00110", ctrl); end
    tick();
    idle_inputs();
    #1;
    n_vec++; if (flush_count !== 4'd1) begin n_err++; $display("FAIL flush_count got %0d exp 1", flush_count); end
    n_vec++; if (stall_count !== 4'd0) begin n_err++; $display("FAIL flush_stall got %0d exp 0", stall_count); end
    n_vec++; if (busy_mask[9] !== 1'b0) begin n_err++; $display("FAIL flush_rd_busy got %b exp 0", busy_mask[9]); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    issue_producer(5'd0, 1'b1);                        // write to X0
    set_id(1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0);           // read X0 twice
    #1;
    n_vec++; if (ctrl !== 5'b00001) begin n_err++; $display("FAIL zero_ctrl got %b exp 00001", ctrl); end
    n_vec++; if (busy_mask !== '0) begin n_err++; $display("FAIL zero_busy got %h exp 0", busy_mask); end
    tick();
    idle_inputs();
    #1;
    n_vec++; if (stall_count !== 4'd0 || busy_mask !== '0) begin n_err++; $display("FAIL zero_after got stall %0d busy %h exp 0", stall_count, busy_mask); end
  endtask

  task automatic test_reset_mid_stall();
    logic [NREG-1:0] exp_busy;
    do_reset();
    issue_producer(5'd5, 1'b1);                        // LDUR X5
    set_id(1, 5'd5, 5'd6, 1, 1, 5'd16, 1, 0);          // SUB X16,X5,X6
    #1;
    n_vec++; if (pc_hold !== 1'b1) begin n_err++; $display("FAIL mid_stall_hold got %b exp 1", pc_hold); end
    tick();
    #1;
    reset = 0;
    #1;
    n_vec++; if (ctrl[4:1] !== 4'b0) begin n_err++; $display("FAIL mid_reset_ctrl got %b exp 0000", ctrl[4:1]); end
    n_vec++; if (busy_mask !== '0 || stall_count !== '0) begin n_err++; $display("FAIL mid_reset_state got busy %h stall %0d exp 0", busy_mask, stall_count); end
    tick();
    reset = 1;
    #1;
    n_vec++; if (ctrl !== 5'b00001) begin n_err++; $display("FAIL after_reset_issue got %b exp 00001", ctrl); end
    tick();
    idle_inputs();
    #1;
`ifdef HAZARD_FORWARDING_EN
    exp_busy = '0;
`else
    exp_busy = 32'h0001_0000;
`endif
    n_vec++; if (busy_mask !== exp_busy || stall_count !== 4'd0) begin n_err++; $display("FAIL after_reset_state got busy %h stall %0d exp %h 0", busy_mask, stall_count, exp_busy); end
  endtask

  task automatic test_random();
    logic v, u1, u2, rw, ld, br, rs1b, rs2b, haz;
    logic [4:0] rs1, rs2, rd;
    logic [4:0] e_ctrl;
    logic [NREG-1:0] e_busy;
    do_reset();
    model_clear();
    mc = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset = 0;
        model_clear();
      end else begin
        reset = 1;
      end
      v   = ($urandom_range(0, 3) != 0);
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      u1  = 1'($urandom_range(0, 1));
      u2  = 1'($urandom_range(0, 1));
      rd  = 5'($urandom_range(0, 7));
      rw  = ($urandom_range(0, 3) != 0);
      ld  = 1'($urandom_range(0, 1));
      br  = ($urandom_range(0, 7) == 0);
      set_id(v, rs1, rs2, u1, u2, rd, rw, ld);
      ex_branch_taken = br;
      #1;
      for (int r = 0; r < NREG; r++) e_busy[r] = (mc < ready_at[r]);
      rs1b = u1 && rs1 != 0 && e_busy[rs1];
      rs2b = u2 && rs2 != 0 && e_busy[rs2];
      haz  = v && (rs1b || rs2b);
      e_ctrl = {!br && haz, !br && haz, br, br || haz, !br && !haz && v};
      n_vec++; if (ctrl !== e_ctrl) begin n_err++; $display("FAIL rand_ctrl cyc %0d got %b exp %b", n, ctrl, e_ctrl); end
      n_vec++; if (busy_mask !== e_busy) begin n_err++; $display("FAIL rand_busy cyc %0d got %h exp %h", n, busy_mask, e_busy); end
      n_vec++; if (stall_count !== CNT_W'(m_stall)) begin n_err++; $display("FAIL rand_stall cyc %0d got %0d exp %0d", n, stall_count, m_stall); end
      n_vec++; if (flush_count !== CNT_W'(m_flush)) begin n_err++; $display("FAIL rand_flush cyc %0d got %0d exp %0d", n, flush_count, m_flush); end
      @(posedge clk);
      if (reset) begin
        if (br) begin
          if (m_flush < CMAX) m_flush++;
        end else if (haz) begin
          if (m_stall < CMAX) m_stall++;
        end
        if (e_ctrl[0] && rw && rd != 0 && lat(ld) > 0) ready_at[rd] = mc + 1 + lat(ld);
      end
      mc++;
      #1;
    end
    reset = 1;
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
`ifdef HAZARD_FORWARDING_EN
    test_load_use();
    test_alu_b2b();
`else
    test_no_forwarding();
`endif
    test_branch_flush();
    test_zero_reg();
    test_reset_mid_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard scheduler for the 5-stage pipelined processor (IF, ID, EX, MEM, WB). It tracks in-flight register writes in a per-register scoreboard and decides each cycle whether the instruction in ID issues, stalls behind a RAW hazard, or is squashed by a taken branch resolved in EX. It replaces hand-inserted NOPs in test programs. It drives the PC hold, IF/ID hold/flush and ID/EX bubble controls, and exposes stall/flush statistics.

## Interface

Parameters:
- `NREG`, 32: number of architectural registers.
- `RW`, 5: register index width, equal to $clog2(NREG).
- `ZERO_REG`, 0: hard-wired zero register; writes to it are never tracked.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `id_valid`  in  1  ID holds a real instruction (not a bubble).
- `id_rs1`, `id_rs2`  in  RW  source register indices of the ID instruction.
- `id_use_rs1`, `id_use_rs2`  in  1  the corresponding source is actually read.
- `id_rd`  in  RW  destination register of the ID instruction.
- `id_reg_write`  in  1  the ID instruction writes `id_rd`.
- `id_is_load`  in  1  the ID instruction is a load (LDUR).
- `ex_branch_taken`  in  1  the branch in EX is taken this cycle.
- `pc_hold`  out  1  PC keeps its value.
- `ifid_hold`  out  1  IF/ID register keeps its value.
- `ifid_flush`  out  1  IF/ID loads a NOP.
- `idex_bubble`  out  1  ID/EX loads a NOP.
- `id_issue`  out  1  the ID instruction advances to EX this cycle.
- `busy_mask`  out  NREG  bit r is 1 while register r has a nonzero scoreboard count.
- `stall_count`  out  CNT_W  number of stall cycles, saturating.
- `flush_count`  out  CNT_W  number of taken-branch flushes, saturating.

## Operation

**Scoreboard**
- One 2-bit down-counter `sb[r]` per register. Each nonzero counter decrements by 1 every cycle, whether or not the pipeline stalls, because bubbles still advance.
- `hazard` = `id_valid` & ((`id_use_rs1` & `sb[id_rs1]`≠0) | (`id_use_rs2` & `sb[id_rs2]`≠0)).
- Any source equal to `ZERO_REG` never hazards.

**Per-cycle priority**
1. `ex_branch_taken`: assert `ifid_flush`=1 and `idex_bubble`=1, with `pc_hold`=`ifid_hold`=0. The ID instruction is squashed: `id_issue`=0 and no scoreboard set. `flush_count` increments.
2. Otherwise, if `hazard`: assert `pc_hold`=`ifid_hold`=`idex_bubble`=1 and `id_issue`=0. `stall_count` increments.
3. Otherwise: `id_issue` = `id_valid` and all hold/flush outputs are 0.

**Scoreboard set**
- Applies on `id_issue` & `id_reg_write` & `id_rd`≠`ZERO_REG`.
- The load value is L (see Configuration). At the same edge, `sb[id_rd]` is loaded with L instead of being decremented.
- If L=0, nothing is tracked.

**Control outputs**
- All control outputs are combinational from the registered scoreboard and the current inputs.
- There is no combinational path from any output back into the scoreboard inputs.

**Statistics counters**
- Saturate at all-ones and never wrap.
- If a branch flush and a hazard occur in the same cycle, only `flush_count` increments.

**Reset**
- Asynchronous assertion at any time, including mid-stall, clears every `sb[r]`, `stall_count` and `flush_count` to 0.
- With `id_valid`=0 and `ex_branch_taken`=0, every output is therefore 0 during and right after reset.
- The first edge after deassertion operates normally.

## Timing

- A producer issued at cycle t is in EX at t+1, MEM at t+2 and WB at t+3.
- The register file writes in the first half-cycle and reads in the second, so WB→ID needs no extra stall.
- Stall length = the L value of the producer minus the number of cycles already elapsed since it issued.
- Hazard detection to hold/bubble outputs: 0 cycles (same cycle).
- Branch redirect: the PC loads the target at t+1 (external). Exactly one flush cycle, so two wrong-path instructions are killed (IF and ID).

## Configuration

Macro: `HAZARD_FORWARDING_EN`.
- Defined (EX/MEM and MEM/WB forwarding present): L=1 for loads and L=0 for ALU ops. Only a load-use pair stalls, for exactly 1 cycle; back-to-back ALU dependencies never stall.
- Undefined (no forwarding): L=2 for every register write. A consumer immediately after its producer stalls 2 cycles; with one independent instruction in between it stalls 1 cycle; with two in between it stalls 0 cycles.

## Test plan

- **Load-use, `HAZARD_FORWARDING_EN` defined:** LDUR X12 issues, then SUB X14,X12,X13 in ID. Required: exactly 1 cycle of `pc_hold`/`idex_bubble`, then `id_issue`=1; `stall_count`=1.
- **Back-to-back ALU ops, forwarding defined:** ADD X11,X1,X10 then LDUR X12,[X11]. Required: no stall cycles and `busy_mask`=0 throughout.
- **No forwarding (macro undefined):** ADD X5 then SUB X16,X5,X6 directly after. Required: 2 stall cycles and `busy_mask[5]` high for 2 cycles. Repeat with one NOP in between: 1 stall cycle.
- **Branch flush with hazard:** `ex_branch_taken`=1 while ID holds a hazarding reader of a pending load. Required: `ifid_flush`=`idex_bubble`=1, `pc_hold`=0; `flush_count` +1 and `stall_count` unchanged; the squashed instruction's `id_rd` is not set busy.
- **Zero-register source:** reads of `ZERO_REG` after a write targeting `ZERO_REG`. Required: no stall cycles and `busy_mask` stays 0.
- **Reset mid-stall:** drop `reset` to 0 during a 2-cycle stall. Required: outputs are 0 immediately and `busy_mask`=0; after release, the same ID instruction issues with no stall.
